// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM. Outputs are registered from the next-state decode,
// so each output changes on the same edge as the state it belongs to.
module mc_controller #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_SLT = 4'b0111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       PCSrc,
  output logic       MemToReg,
  output logic       IorD,
  output logic       MemWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e     r_state;
  logic       r_pcwrite, r_branch, r_irwrite, r_regwrite, r_regdst, r_alusrca;
  logic [1:0] r_alusrcb;
  logic [3:0] r_aluctl;
  logic       r_pcsrc, r_memtoreg, r_iord, r_memwrite;

  state_e     w_state_d;
  logic       w_funct_ok;
  logic [3:0] w_funct_ctl;
  logic       w_pcwrite, w_branch, w_irwrite, w_regwrite, w_regdst, w_alusrca;
  logic [1:0] w_alusrcb;
  logic [3:0] w_aluctl;
  logic       w_pcsrc, w_memtoreg, w_iord, w_memwrite;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_ctl = ALU_ADD;
    unique case (funct)
      6'b100000: w_funct_ctl = ALU_ADD;
      6'b100010: w_funct_ctl = ALU_SUB;
      6'b100100: w_funct_ctl = ALU_AND;
      6'b100101: w_funct_ctl = ALU_OR;
      6'b101010: w_funct_ctl = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = StFetch;
    unique case (r_state)
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw: w_state_d = StMemAdr;
          OpRtype:    w_state_d = StExecute;
          OpBeq:      w_state_d = StBranch;
          OpAddi:     w_state_d = StAddiExec;
          default:    w_state_d = StFetch;
        endcase
      end
      // Opcode is still in the IR here; anything but lw/sw falls back to fetch.
      StMemAdr: begin
        if (opcode == OpLw)      w_state_d = StMemRead;
        else if (opcode == OpSw) w_state_d = StMemWrite;
        else                     w_state_d = StFetch;
      end
      StMemRead:  w_state_d = StMemWb;
      StExecute:  w_state_d = w_funct_ok ? StAluWb : StFetch;
      StAddiExec: w_state_d = StAddiWb;
      default:    w_state_d = StFetch;
    endcase
  end

  // Decode of the state being entered; registered below.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluctl   = ALU_ADD;
    w_pcsrc    = 1'b0;
    w_memtoreg = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    unique case (w_state_d)
      StFetch: begin
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
      end
      StDecode:  w_alusrcb = 2'b11;
      StMemAdr: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      StMemRead: w_iord = 1'b1;
      StMemWb: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      StMemWrite: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      StExecute: begin
        w_alusrca = 1'b1;
        w_aluctl  = w_funct_ctl;
      end
      StAluWb: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      StBranch: begin
        w_alusrca = 1'b1;
        w_aluctl  = ALU_SUB;
        w_pcsrc   = 1'b1;
        w_branch  = 1'b1;
      end
      StAddiExec: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      StAddiWb:  w_regwrite = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StFetch;
      r_pcwrite  <= 1'b1;
      r_branch   <= 1'b0;
      r_irwrite  <= 1'b1;
      r_regwrite <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b01;
      r_aluctl   <= ALU_ADD;
      r_pcsrc    <= 1'b0;
      r_memtoreg <= 1'b0;
      r_iord     <= 1'b0;
      r_memwrite <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pcwrite  <= w_pcwrite;
      r_branch   <= w_branch;
      r_irwrite  <= w_irwrite;
      r_regwrite <= w_regwrite;
      r_regdst   <= w_regdst;
      r_alusrca  <= w_alusrca;
      r_alusrcb  <= w_alusrcb;
      r_aluctl   <= w_aluctl;
      r_pcsrc    <= w_pcsrc;
      r_memtoreg <= w_memtoreg;
      r_iord     <= w_iord;
      r_memwrite <= w_memwrite;
    end
  end

  assign PCEn       = r_pcwrite | (r_branch & Zero);
  assign IRWrite    = r_irwrite;
  assign RegWrite   = r_regwrite;
  assign RegDst     = r_regdst;
  assign ALUSrcA    = r_alusrca;
  assign ALUSrcB    = r_alusrcb;
  assign ALUControl = r_aluctl;
  assign PCSrc      = r_pcsrc;
  assign MemToReg   = r_memtoreg;
  assign IorD       = r_iord;
  assign MemWrite   = r_memwrite;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction reference model queues the expected
// output vector for every cycle, and a monitor compares it on each falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       Zero;
  logic       PCEn, IRWrite, RegWrite, RegDst, ALUSrcA, PCSrc, MemToReg, IorD, MemWrite;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl, state;

  int checks = 0;
  int errors = 0;
  logic [18:0] q_exp[$];

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .PCEn(PCEn), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .MemToReg(MemToReg), .IorD(IorD), .MemWrite(MemWrite), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] act_vec();
    return {state, PCEn, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUControl,
            PCSrc, MemToReg, IorD, MemWrite};
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected outputs for one cycle spent in state st.
  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] fn, input logic z);
    logic [1:0] srcb;
    logic [3:0] alu;
    srcb = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 9) ? 2'b10 : 2'b00;
    alu  = (st == 6) ? funct_alu(fn) : (st == 8) ? 4'b0110 : 4'b0010;
    return {st[3:0], (st == 0) || (st == 8 && z == 1'b1), st == 0,
            st == 4 || st == 7 || st == 10, st == 7, st inside {2, 6, 8, 9}, srcb, alu,
            st == 8, st == 4, st == 3 || st == 5, st == 5};
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int seq[$];
    opcode = op;
    funct  = fn;
    Zero   = z;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = funct_legal(fn) ? '{0, 1, 6, 7} : '{0, 1, 6};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      default:   seq = '{0, 1};
    endcase
    foreach (seq[i]) q_exp.push_back(exp_vec(seq[i], fn, z));
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    checks++;
    if (state !== 4'd0 || PCEn !== 1'b1 || IRWrite !== 1'b1 || RegWrite !== 1'b0 ||
        MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%0d PCEn=%b IRWrite=%b RegWrite=%b MemWrite=%b, required 0 1 1 0 0",
               name, state, PCEn, IRWrite, RegWrite, MemWrite);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && q_exp.size() > 0) begin
      logic [18:0] e, a;
      e = q_exp.pop_front();
      a = act_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t op=%b fn=%b Z=%b: got %b required %b",
                 $time, opcode, funct, Zero, a, e);
      end
      checks++;
      if (int'(RegWrite) + int'(MemWrite) + int'(IRWrite) > 1) begin
        errors++;
        $display("FAIL one_strobe t=%0t: RegWrite=%b MemWrite=%b IRWrite=%b, required at most one",
                 $time, RegWrite, MemWrite, IRWrite);
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] legal_fn[5];
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b0; opcode = '0; funct = '0; Zero = 1'b0;
    #12;
    check_reset_outs("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases from the test plan.
    run_instr(6'b100011, 6'b000000, 1'b0);
    run_instr(6'b101011, 6'b000000, 1'b1);
    run_instr(6'b000000, 6'b101010, 1'b0);
    run_instr(6'b000000, 6'b100010, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    run_instr(6'b111111, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b111111, 1'b0);

    // Reset asserted mid-lw while in MEMREAD.
    opcode = 6'b100011; funct = '0; Zero = 1'b0;
    for (int s = 0; s < 4; s++) q_exp.push_back(exp_vec(s, 6'b000000, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_outs("async_reset_mid_lw");
    @(posedge clk); #1;
    check_reset_outs("held_reset");
    reset = 1'b1;
    run_instr(6'b001000, 6'b000000, 1'b0);

    for (int n = 0; n < 80; n++) begin
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'($urandom);
        default: op = 6'b111111;
      endcase
      run_instr(op, fn, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS main control unit; sits directly alongside and upstream of mc_datapath.
- Consumes opcode, funct and Zero from the datapath.
- Drives every datapath select/enable plus the external memory write strobe.
- Moore FSM: outputs decoded from state only; PCEn additionally combines Zero for beq.

Parameters:
ALU_ADD, 4'b0010, ALUControl code for add
ALU_SUB, 4'b0110, ALUControl code for subtract
ALU_AND, 4'b0000, ALUControl code for and
ALU_OR, 4'b0001, ALUControl code for or
ALU_SLT, 4'b0111, ALUControl code for set-less-than

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
opcode  input  6  Instr[31:26] from datapath
funct  input  6  Instr[5:0] from datapath
Zero  input  1  ALU zero flag
PCEn  output  1  PC register enable
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file write enable
RegDst  output  1  0: rt is destination, 1: rd is destination
ALUSrcA  output  1  0: pc, 1: A
ALUSrcB  output  2  00: B, 01: constant 4, 10: SignImm, 11: SignImmSl2
ALUControl  output  4  ALU operation code (parameters above)
PCSrc  output  1  0: ALUResult, 1: ALUOut
MemToReg  output  1  0: ALUOut, 1: Data
IorD  output  1  0: pc address, 1: ALUOut address
MemWrite  output  1  external memory write strobe
state  output  4  current state, exposed for the bench

Behaviour:
- Reset: asynchronous on reset==0; state = FETCH (0). Outputs then reflect FETCH decoding, so PCEn=1 and IRWrite=1 are legal while in reset.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10. Codes 11-15 are illegal and go to FETCH on the next edge.
- Default for every output not listed in a state: 0. ALUControl defaults to ALU_ADD.
- PCEn = PCWrite | (Branch & Zero). PCWrite and Branch are internal Moore signals.
- FETCH:
  - IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_ADD, PCSrc=0, PCWrite=1.
  - Next: DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALU_ADD (branch target into ALUOut).
  - Next by opcode: 100011 lw / 101011 sw -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC.
  - Any other opcode -> FETCH, with no register or memory write.
- MEMADR:
  - ALUSrcA=1, ALUSrcB=10, ALU_ADD.
  - Next: lw -> MEMREAD, sw -> MEMWRITE.
  - Opcode is still held in the IR, so it is re-sampled here.
- MEMREAD: IorD=1. Next: MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Next: FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Next: FETCH.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUControl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next: ALUWB for a legal funct. Unknown funct -> FETCH (no writeback); ALUControl=ALU_ADD for that cycle.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1. Next: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALU_SUB, PCSrc=1, Branch=1.
  - PCEn=1 only when Zero==1. Next: FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU_ADD. Next: ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Next: FETCH.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- At most one of RegWrite / MemWrite / IRWrite is asserted in any cycle.
- Reset mid-instruction: state immediately FETCH; any in-progress write is abandoned. No write strobe may be asserted from the first cycle of reset until the state leaves FETCH.

Test Plan:
- Reset low, then high; opcode=100011 -> state sequence 0,1,2,3,4,0. MemWrite=0 throughout. RegWrite=1 with MemToReg=1, RegDst=0 only in state 4. PCEn=1 only in state 0.
- opcode=101011 -> sequence 0,1,2,5,0. MemWrite=1 and IorD=1 only in state 5. RegWrite never asserted.
- opcode=000000, funct=101010 -> state 6 gives ALUControl=0111, ALUSrcA=1, ALUSrcB=00. State 7 gives RegWrite=1, RegDst=1. Repeat with funct=100010 -> ALUControl=0110.
- opcode=000100 with Zero=1 in state 8 -> PCEn=1, PCSrc=1. Same with Zero=0 -> PCEn=0. Both cases return to FETCH after 3 cycles.
- opcode=111111 -> 0,1,0 with no write strobes. opcode=000000 with funct=111111 -> 0,1,6,0 with RegWrite never asserted.
- Pull reset low while in state 3 (lw) -> state=0 asynchronously, before the next edge. Release, run addi (001000) -> 0,1,9,10,0 with RegWrite=1 only in state 10.
